// File: rtl/alu_ctrl_issue_if.sv
// Bundle interface between IF, the decode/issue stage and EX.
//   in_valid/in_ready/instr/pc : fetched instruction from IF
//   out_valid/out_ready        : decoded bundle handshake toward EX
//   aluctrl, aluctrl1, asel, bsel, imm, rs1, rs2, rd, regwrite, illegal, pc_out : decoded bundle
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. A valid bundle stays stable until it is taken; ready never
// depends combinationally on valid.
// Modports: master = IF/EX environment side, slave = decode/issue stage.
interface alu_ctrl_issue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      aluctrl;
  logic [2:0]      aluctrl1;
  logic [1:0]      asel;
  logic            bsel;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            regwrite;
  logic            illegal;
  logic [XLEN-1:0] pc_out;

  modport master (
    output in_valid, instr, pc, out_ready,
    input  in_ready, out_valid, aluctrl, aluctrl1, asel, bsel, imm,
           rs1, rs2, rd, regwrite, illegal, pc_out
  );

  modport slave (
    input  in_valid, instr, pc, out_ready,
    output in_ready, out_valid, aluctrl, aluctrl1, asel, bsel, imm,
           rs1, rs2, rd, regwrite, illegal, pc_out
  );
endinterface

// File: rtl/alu_ctrl_issue.sv
// RV32I decode stage feeding the ALU, with a 2-entry skid buffer.
// Ports:
//   clk       : clock, rising edge
//   rstn      : synchronous active-low reset
//   flush     : drop all buffered entries and the input of this cycle
//   bus       : alu_ctrl_issue_if.slave (instruction in, decoded bundle out)
//   state_dbg : current skid FSM state (0 EMPTY, 1 ONE, 2 TWO)
// ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7,
//            OR 8, AND 9, LUI 10, AUIPC 11.
// Branch codes: 0 none, BEQ 1, BNE 2, BLT 3, BGE 4, BLTU 5, BGEU 6.
module alu_ctrl_issue #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  alu_ctrl_issue_if.slave     bus,
  output logic [1:0]          state_dbg
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
    ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6,
    ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_LUI = 4'd10,
    ALU_AUIPC = 4'd11;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011,
    OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_BRANCH = 7'b1100011,
    OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_JALR = 7'b1100111,
    OPC_JAL = 7'b1101111;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [3:0]      aluctrl;
    logic [2:0]      aluctrl1;
    logic [1:0]      asel;
    logic            bsel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  // funct3 -> register/immediate ALU op; alt selects SUB/SRA
  function automatic logic [3:0] rr_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  rr_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  rr_op = ALU_SLL;
      3'b010:  rr_op = ALU_SLT;
      3'b011:  rr_op = ALU_SLTU;
      3'b100:  rr_op = ALU_XOR;
      3'b101:  rr_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  rr_op = ALU_OR;
      default: rr_op = ALU_AND;
    endcase
  endfunction

  // ---------------- decode ----------------
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            wr, bad;
  bundle_t         dec;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign imm_i  = XLEN'($signed(bus.instr[31:20]));
  assign imm_s  = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
  assign imm_b  = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25],
                                 bus.instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({bus.instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({bus.instr[31], bus.instr[19:12], bus.instr[20],
                                 bus.instr[30:21], 1'b0}));

  always_comb begin
    dec         = '0;
    wr          = 1'b0;
    bad         = 1'b0;
    dec.rs1     = bus.instr[19:15];
    dec.rs2     = bus.instr[24:20];
    dec.rd      = bus.instr[11:7];
    dec.pc      = bus.pc;
    dec.aluctrl = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        wr          = 1'b1;
        dec.aluctrl = rr_op(funct3, funct7[5]);
        bad = !((funct7 == F7_BASE) ||
                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OPIMM: begin
        wr          = 1'b1;
        dec.bsel    = 1'b1;
        dec.imm     = imm_i;
        // funct7 only exists on shifts; elsewhere those bits are immediate
        dec.aluctrl = rr_op(funct3, funct3 == 3'b101 && funct7[5]);
        if (funct3 == 3'b001)
          bad = (funct7 != F7_BASE);
        else if (funct3 == 3'b101)
          bad = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OPC_LUI: begin
        wr = 1'b1; dec.aluctrl = ALU_LUI; dec.asel = 2'd2; dec.bsel = 1'b1; dec.imm = imm_u;
      end
      OPC_AUIPC: begin
        wr = 1'b1; dec.aluctrl = ALU_AUIPC; dec.asel = 2'd1; dec.bsel = 1'b1; dec.imm = imm_u;
      end
      OPC_BRANCH: begin
        dec.aluctrl = ALU_SUB;
        dec.imm     = imm_b;
        case (funct3)
          3'b000:  dec.aluctrl1 = 3'd1;
          3'b001:  dec.aluctrl1 = 3'd2;
          3'b100:  dec.aluctrl1 = 3'd3;
          3'b101:  dec.aluctrl1 = 3'd4;
          3'b110:  dec.aluctrl1 = 3'd5;
          3'b111:  dec.aluctrl1 = 3'd6;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD:  begin wr = 1'b1; dec.bsel = 1'b1; dec.imm = imm_i; end
      OPC_STORE: begin dec.bsel = 1'b1; dec.imm = imm_s; end
      OPC_JALR:  begin wr = 1'b1; dec.bsel = 1'b1; dec.imm = imm_i; end
      OPC_JAL:   begin wr = 1'b1; dec.asel = 2'd1; dec.bsel = 1'b1; dec.imm = imm_j; end
      default:   bad = 1'b1;
    endcase
    // An illegal word travels on as a harmless ADD with neutral operand
    // selects; register fields and pc are kept for trap reporting.
    if (bad) begin
      dec.aluctrl  = ALU_ADD;
      dec.aluctrl1 = 3'd0;
      dec.asel     = 2'd0;
      dec.bsel     = 1'b0;
      dec.imm      = '0;
      wr           = 1'b0;
    end
    dec.illegal  = bad;
    dec.regwrite = wr && (dec.rd != 5'd0);
  end

  // ---------------- skid buffer ----------------
  state_t  state_q, state_d;
  logic    in_ready_q;
  bundle_t head_q, tail_q;
  logic    push, pop;

  assign push = bus.in_valid && in_ready_q;
  assign pop  = (state_q != EMPTY) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE:     if (push && !pop) state_d = TWO;
               else if (pop && !push) state_d = EMPTY;
      TWO:     if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      // ready is a flop so EX's out_ready never reaches IF combinationally
      in_ready_q <= (state_d != TWO);
      // on flush head keeps its value: payload holds while out_valid=0
      if (!flush) begin
        case (state_q)
          EMPTY: if (push) head_q <= dec;
          ONE: begin
            if (push && pop) head_q <= dec;
            else if (push) tail_q <= dec;
          end
          TWO: if (pop) head_q <= tail_q;
          default: ;
        endcase
      end
    end
  end

  assign state_dbg     = state_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.aluctrl   = head_q.aluctrl;
  assign bus.aluctrl1  = head_q.aluctrl1;
  assign bus.asel      = head_q.asel;
  assign bus.bsel      = head_q.bsel;
  assign bus.imm       = head_q.imm;
  assign bus.rs1       = head_q.rs1;
  assign bus.rs2       = head_q.rs2;
  assign bus.rd        = head_q.rd;
  assign bus.regwrite  = head_q.regwrite;
  assign bus.illegal   = head_q.illegal;
  assign bus.pc_out    = head_q.pc;
endmodule

// File: tb/tb_alu_ctrl_issue.sv
module tb_alu_ctrl_issue;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3,
    SLTU = 4'd4, XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9,
    LUI = 4'd10, AUIPC = 4'd11;

  typedef struct packed {
    logic [3:0]  aluctrl;
    logic [2:0]  aluctrl1;
    logic [1:0]  asel;
    logic        bsel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regwrite;
    logic        illegal;
    logic [31:0] pc;
  } bundle_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] state_dbg;
  bit         started = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_issue_if #(.XLEN(32)) bus ();
  alu_ctrl_issue #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus), .state_dbg(state_dbg)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction semantics from the ISA tables: register ops indexed by funct3,
  // branches mapped from funct3, immediates rebuilt as signed integers.
  function automatic bundle_t model_decode(input logic [31:0] w, input logic [31:0] p);
    bundle_t b;
    logic [3:0] base_op [8];
    logic [2:0] br_code [8];
    logic [2:0] f3;
    logic [6:0] f7;
    int         ii, is, ib, iu, ij;
    bit         ok, wr;
    base_op = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    br_code = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
    f3 = w[14:12];
    f7 = w[31:25];
    ii = $signed(w) >>> 20;
    is = ((($signed(w) >>> 25)) * 32) + int'(w[11:7]);
    ib = ((($signed(w) >>> 31)) * 4096) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    iu = int'({w[31:12], 12'h000});
    ij = ((($signed(w) >>> 31)) * 1048576) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    b = '0;
    b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7]; b.pc = p;
    ok = 1; wr = 1;
    case (w[6:0])
      7'h33: begin
        b.aluctrl = base_op[f3];
        if (f7 == 7'h20 && f3 == 3'd0) b.aluctrl = SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) b.aluctrl = SRA;
        else if (f7 != 7'h00) ok = 0;
      end
      7'h13: begin
        b.aluctrl = base_op[f3]; b.bsel = 1; b.imm = ii;
        if (f3 == 3'd1 && f7 != 7'h00) ok = 0;
        if (f3 == 3'd5 && f7 == 7'h20) b.aluctrl = SRA;
        else if (f3 == 3'd5 && f7 != 7'h00) ok = 0;
      end
      7'h37: begin b.aluctrl = LUI;   b.asel = 2; b.bsel = 1; b.imm = iu; end
      7'h17: begin b.aluctrl = AUIPC; b.asel = 1; b.bsel = 1; b.imm = iu; end
      7'h63: begin
        b.aluctrl = SUB; b.aluctrl1 = br_code[f3]; b.imm = ib; wr = 0;
        if (br_code[f3] == 3'd0) ok = 0;
      end
      7'h03, 7'h67: begin b.aluctrl = ADD; b.bsel = 1; b.imm = ii; end
      7'h23: begin b.aluctrl = ADD; b.bsel = 1; b.imm = is; wr = 0; end
      7'h6F: begin b.aluctrl = ADD; b.asel = 1; b.bsel = 1; b.imm = ij; end
      default: ok = 0;
    endcase
    if (!ok) begin
      b.aluctrl = ADD; b.aluctrl1 = 0; b.asel = 0; b.bsel = 0; b.imm = 0; wr = 0;
    end
    b.illegal  = !ok;
    b.regwrite = wr && (b.rd != 0);
    return b;
  endfunction

  bundle_t exp_q[$];
  bundle_t shown = '0;

  // Model of the buffer: at most two entries in FIFO order, acceptance
  // decided by the occupancy before the edge.
  initial forever begin
    @(posedge clk);
    if (!rstn || flush) begin
      exp_q.delete();
      if (!rstn) shown = '0;
    end else begin
      bit take, give;
      take = bus.in_valid && (exp_q.size() < 2);
      give = (exp_q.size() > 0) && bus.out_ready;
      if (give) void'(exp_q.pop_front());
      if (take) exp_q.push_back(model_decode(bus.instr, bus.pc));
    end
    if (exp_q.size() > 0) shown = exp_q[0];
  end

  function automatic bundle_t dut_bundle();
    bundle_t b;
    b.aluctrl = bus.aluctrl; b.aluctrl1 = bus.aluctrl1; b.asel = bus.asel;
    b.bsel = bus.bsel; b.imm = bus.imm; b.rs1 = bus.rs1; b.rs2 = bus.rs2;
    b.rd = bus.rd; b.regwrite = bus.regwrite; b.illegal = bus.illegal;
    b.pc = bus.pc_out;
    return b;
  endfunction

  // ---------------- scoreboard compare ----------------
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("out_valid", bus.out_valid, exp_q.size() > 0);
      check("in_ready", bus.in_ready, exp_q.size() < 2);
      check("payload", dut_bundle(), shown);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [31:0] w, input logic [31:0] p, input bit ordy);
    bus.in_valid  = v;
    bus.instr     = w;
    bus.pc        = p;
    bus.out_ready = ordy;
    @(negedge clk);
  endtask

  localparam logic [31:0] I_ADD = 32'h002081B3, I_SRAI = 32'h40335293,
    I_SUB = 32'h403100B3, I_BLTU = 32'hFE20ECE3, I_LUI = 32'h123453B7,
    I_SW = 32'h0020A423, I_JAL = 32'hFFDFF0EF, I_ADDX0 = 32'h00208033,
    I_MUL = 32'h022081B3, I_XOR = 32'h0062C233, I_OR = 32'h009463B3,
    I_BAD = 32'h0000007F;

  logic [31:0] extra [12] = '{32'hFFF00093, 32'h00001117, 32'h0040A183,
    32'h000280E7, 32'h00208863, 32'h0020A863, 32'h40109093, 32'h003130B3,
    32'h003170B3, 32'h003150B3, 32'h403150B3, 32'h00512093};

  initial begin
    bundle_t m;
    bus.in_valid = 0; bus.instr = 0; bus.pc = 0; bus.out_ready = 1;

    // model pinned against hand-decoded words
    m = model_decode(I_BLTU, 32'h0);
    check("model_bltu_imm", m.imm, 32'hFFFFFFF8);
    check("model_bltu_b", m.aluctrl1, 3'b101);
    m = model_decode(I_SW, 32'h0);
    check("model_sw_imm", m.imm, 32'd8);
    m = model_decode(I_JAL, 32'h0);
    check("model_jal_imm", m.imm, 32'hFFFFFFFC);

    // reset
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_payload", dut_bundle(), '0);
    check("rst_state", state_dbg, 2'd0);
    rstn = 1;
    started = 1;

    // back-to-back decode, one cycle latency
    step(1, I_ADD, 32'h100, 1);
    check("add_valid", bus.out_valid, 1'b1);
    check("add_ctrl", {bus.aluctrl, bus.asel, bus.bsel, bus.rd, bus.regwrite},
          {ADD, 2'd0, 1'b0, 5'd3, 1'b1});
    step(1, I_SRAI, 32'h104, 1);
    check("srai_ctrl", {bus.aluctrl, bus.bsel, bus.imm[4:0]}, {SRA, 1'b1, 5'd3});
    step(1, I_SUB, 32'h108, 1);
    check("sub_ctrl", bus.aluctrl, SUB);
    step(1, I_BLTU, 32'h10C, 1);
    check("bltu_ctrl", {bus.aluctrl1, bus.aluctrl, bus.regwrite}, {3'b101, SUB, 1'b0});
    check("bltu_imm", bus.imm, 32'hFFFFFFF8);
    step(1, I_LUI, 32'h110, 1);
    check("lui_ctrl", {bus.aluctrl, bus.asel, bus.bsel, bus.imm}, {LUI, 2'd2, 1'b1, 32'h12345000});
    step(1, I_SW, 32'h114, 1);
    check("sw_ctrl", {bus.regwrite, bus.bsel, bus.imm}, {1'b0, 1'b1, 32'd8});
    step(1, I_JAL, 32'h118, 1);
    check("jal_ctrl", {bus.asel, bus.bsel, bus.imm, bus.pc_out}, {2'd1, 1'b1, 32'hFFFFFFFC, 32'h118});
    step(1, I_ADDX0, 32'h11C, 1);
    check("x0_regwrite", bus.regwrite, 1'b0);
    step(1, I_MUL, 32'h120, 1);
    check("mul_illegal", {bus.illegal, bus.regwrite, bus.aluctrl}, {1'b1, 1'b0, ADD});
    for (int i = 0; i < 12; i++) step(1, extra[i], 32'h200 + 32'(i * 4), 1);
    step(0, 0, 0, 1);
    check("drain_empty", bus.out_valid, 1'b0);

    // backpressure
    step(1, I_XOR, 32'h300, 0);
    check("bp_first", {bus.out_valid, bus.in_ready, bus.rd}, {1'b1, 1'b1, 5'd4});
    step(1, I_OR, 32'h304, 0);
    check("bp_full", {bus.in_ready, bus.rd, bus.aluctrl}, {1'b0, 5'd4, XOR});
    step(0, 0, 0, 0);
    check("bp_hold", {bus.out_valid, bus.pc_out}, {1'b1, 32'h300});
    step(0, 0, 0, 1);
    check("bp_second", {bus.out_valid, bus.in_ready, bus.rd, bus.aluctrl}, {1'b1, 1'b1, 5'd7, OR});
    step(0, 0, 0, 1);
    check("bp_drained", bus.out_valid, 1'b0);

    // flush in TWO with an input presented
    step(1, I_ADD, 32'h400, 0);
    step(1, I_SUB, 32'h404, 0);
    check("fl_two", state_dbg, 2'd2);
    flush = 1;
    step(1, I_LUI, 32'h408, 0);
    flush = 0;
    check("fl_empty", {bus.out_valid, bus.in_ready}, {1'b0, 1'b1});
    step(0, 0, 0, 1);
    check("fl_dropped", bus.out_valid, 1'b0);

    // reset mid-operation, then an illegal opcode
    step(1, I_XOR, 32'h500, 0);
    check("rs_one", state_dbg, 2'd1);
    rstn = 0;
    step(0, 0, 0, 0);
    rstn = 1;
    check("rs_cleared", {bus.out_valid, bus.in_ready, bus.pc_out}, {1'b0, 1'b1, 32'h0});
    step(1, I_BAD, 32'h600, 1);
    check("bad_bundle", {bus.out_valid, bus.illegal, bus.regwrite, bus.aluctrl1, bus.aluctrl},
          {1'b1, 1'b1, 1'b0, 3'd0, ADD});
    check("bad_pc", bus.pc_out, 32'h600);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
